// File: rtl/fifo9_gmii_tx_framer_pkg.sv
// Shared definitions for the per-port GMII transmit framer.
// Holds the GMII framing constants, the CRC-32 polynomial/init/residue
// values, the framer state encoding and a helper that picks one FCS byte
// out of the running CRC register.
package fifo9_gmii_tx_framer_pkg;

  // GMII framing bytes
  localparam logic [7:0] PREAMBLE = 8'h55;
  localparam logic [7:0] SFD      = 8'hD5;

  // IEEE 802.3 CRC-32, reflected (LSB-first) form of 0x04C11DB7
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_DATA,
    ST_PAD,
    ST_FCS,
    ST_ABORT,
    ST_DRAIN,
    ST_IFG
  } state_e;

  // The FCS is the inverted CRC register sent least significant byte first
  function automatic logic [7:0] fcs_byte(input logic [31:0] crc, input logic [1:0] idx);
    logic [31:0] shifted;
    shifted = (~crc) >> {idx, 3'b000};
    return shifted[7:0];
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational CRC-32 next-state function, one byte per clock.
// Ports:
//   crc_in  [31:0]  current CRC register
//   d       [7:0]   byte to fold in (bit 0 is transmitted first)
//   crc_out [31:0]  CRC register after absorbing d
module crc32_d8
  import fifo9_gmii_tx_framer_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  d,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  // Eight LSB-first shift steps of the reflected polynomial, unrolled by synthesis
  always_comb begin
    c = crc_in ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/fifo9_gmii_tx_framer.sv
// Per-port GMII transmit framer in the gmii_tx_clk domain.
// Reads 9-bit FWFT FIFO entries ([8]=1 frame byte, [8]=0 frame separator)
// holding DA..payload, and drives preamble, SFD, data, zero pad up to
// MinFrame, the CRC-32 FCS and the inter-frame gap onto GMII.
// Ports:
//   gmii_tx_clk    clock
//   sys_rst        asynchronous active-high reset
//   dout[8:0]      FIFO head, valid when empty=0
//   empty          FIFO empty
//   rd_en          pop the FIFO head this cycle (combinational)
//   gmii_tx_en     GMII transmit enable (registered)
//   gmii_txd[7:0]  GMII transmit data (registered)
//   gmii_tx_er     GMII transmit error (registered)
//   tx_frame_done  pulse with the last FCS byte of a good frame
//   tx_underrun    pulse with the abort byte when the FIFO ran dry mid-frame
module fifo9_gmii_tx_framer
  import fifo9_gmii_tx_framer_pkg::*;
#(
  parameter int PreambleLen = 7,
  parameter int MinFrame    = 60,
  parameter int MaxFrame    = 1514,
  parameter int Ifg         = 12
) (
  input  logic       gmii_tx_clk,
  input  logic       sys_rst,
  input  logic [8:0] dout,
  input  logic       empty,
  output logic       rd_en,
  output logic       gmii_tx_en,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_er,
  output logic       tx_frame_done,
  output logic       tx_underrun
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [10:0] bcnt_q, bcnt_d;
  logic [10:0] bcnt_inc;
  logic [31:0] crc_q, crc_d;
  logic [31:0] crc_next;
  logic [7:0]  crc_din;
  logic        tx_en_q, tx_en_d;
  logic [7:0]  txd_q, txd_d;
  logic        tx_er_q, tx_er_d;
  logic        done_q, done_d;
  logic        underrun_q, underrun_d;
  logic        in_data;

  // The decision made in a cycle lands on the wire the next cycle, so the
  // separator lookahead in DATA can load a pad or FCS byte straight into the
  // output register and tx_en never drops inside a frame.
  assign in_data  = (state_q == ST_SFD) || (state_q == ST_DATA);
  assign bcnt_inc = (bcnt_q == 11'h7FF) ? bcnt_q : bcnt_q + 11'd1;
  assign crc_din  = (in_data && dout[8]) ? dout[7:0] : 8'h00;

  crc32_d8 u_crc (
    .crc_in  (crc_q),
    .d       (crc_din),
    .crc_out (crc_next)
  );

  // Next-state and next-output logic; cnt_q is the preamble index, the FCS
  // byte index or the gap counter depending on state
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bcnt_d     = bcnt_q;
    crc_d      = crc_q;
    tx_en_d    = 1'b0;
    txd_d      = 8'h00;
    tx_er_d    = 1'b0;
    done_d     = 1'b0;
    underrun_d = 1'b0;
    rd_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          if (dout[8]) begin
            state_d = ST_PRE;
            cnt_d   = 4'd1;
            tx_en_d = 1'b1;
            txd_d   = PREAMBLE;
          end else begin
            rd_en = 1'b1;
          end
        end
      end

      ST_PRE: begin
        tx_en_d = 1'b1;
        if (cnt_q == 4'(PreambleLen)) begin
          state_d = ST_SFD;
          txd_d   = SFD;
          crc_d   = CRC32_INIT;
          bcnt_d  = 11'd0;
        end else begin
          txd_d = PREAMBLE;
          cnt_d = cnt_q + 4'd1;
        end
      end

      // SFD is on the wire while the first data byte is being fetched, so it
      // shares the data decision; empty is tested first so underrun wins
      ST_SFD, ST_DATA: begin
        tx_en_d = 1'b1;
        if (empty) begin
          state_d    = ST_ABORT;
          tx_er_d    = 1'b1;
          underrun_d = 1'b1;
        end else if (dout[8]) begin
          rd_en = 1'b1;
          if (bcnt_q == 11'(MaxFrame)) begin
            state_d = ST_ABORT;
            tx_er_d = 1'b1;
          end else begin
            state_d = ST_DATA;
            txd_d   = dout[7:0];
            crc_d   = crc_next;
            bcnt_d  = bcnt_inc;
          end
        end else begin
          rd_en = 1'b1;
          if (bcnt_q < 11'(MinFrame)) begin
            state_d = ST_PAD;
            crc_d   = crc_next;
            bcnt_d  = bcnt_inc;
          end else begin
            state_d = ST_FCS;
            txd_d   = fcs_byte(crc_q, 2'd0);
            cnt_d   = 4'd0;
          end
        end
      end

      ST_PAD: begin
        tx_en_d = 1'b1;
        if (bcnt_q < 11'(MinFrame)) begin
          crc_d  = crc_next;
          bcnt_d = bcnt_inc;
        end else begin
          state_d = ST_FCS;
          txd_d   = fcs_byte(crc_q, 2'd0);
          cnt_d   = 4'd0;
        end
      end

      ST_FCS: begin
        if (cnt_q == 4'd3) begin
          state_d = ST_IFG;
          cnt_d   = 4'd1;
        end else begin
          tx_en_d = 1'b1;
          txd_d   = fcs_byte(crc_q, cnt_q[1:0] + 2'd1);
          cnt_d   = cnt_q + 4'd1;
          done_d  = (cnt_q == 4'd2);
        end
      end

      ST_ABORT: begin
        state_d = ST_DRAIN;
      end

      ST_DRAIN: begin
        if (!empty) begin
          rd_en = 1'b1;
          if (!dout[8]) begin
            state_d = ST_IFG;
            cnt_d   = 4'd1;
          end
        end
      end

      // The IDLE cycle that launches the next preamble is itself idle on the
      // wire, so IFG holds for one cycle less than the full gap
      ST_IFG: begin
        if (cnt_q >= 4'(Ifg - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and the registered GMII outputs
  always_ff @(posedge gmii_tx_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      bcnt_q     <= 11'd0;
      crc_q      <= 32'h0;
      tx_en_q    <= 1'b0;
      txd_q      <= 8'h00;
      tx_er_q    <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bcnt_q     <= bcnt_d;
      crc_q      <= crc_d;
      tx_en_q    <= tx_en_d;
      txd_q      <= txd_d;
      tx_er_q    <= tx_er_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
    end
  end

  assign gmii_tx_en    = tx_en_q;
  assign gmii_txd      = txd_q;
  assign gmii_tx_er    = tx_er_q;
  assign tx_frame_done = done_q;
  assign tx_underrun   = underrun_q;

endmodule

// File: tb/tb_fifo9_gmii_tx_framer.sv
// Testbench for fifo9_gmii_tx_framer: a queue-backed FWFT FIFO feeds the
// framer, and an expected wire stream built from frame-level rules is
// compared against the GMII outputs on every cycle.
module tb_fifo9_gmii_tx_framer;
  import fifo9_gmii_tx_framer_pkg::*;

  logic       gmii_tx_clk = 1'b0;
  logic       sys_rst;
  logic [8:0] dout;
  logic       empty;
  logic       rd_en;
  logic       gmii_tx_en;
  logic [7:0] gmii_txd;
  logic       gmii_tx_er;
  logic       tx_frame_done;
  logic       tx_underrun;

  typedef struct packed {
    logic       er;
    logic [7:0] txd;
    logic       done;
    logic       underrun;
  } exp_t;

  exp_t        exp_q[$];
  logic [8:0]  fifo_q[$];
  logic [7:0]  rx_q[$];
  logic [31:0] crc_table [256];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int underrun_cnt = 0;
  int last_len = 0;
  int last_gap = 0;
  int burst_len = 0;
  int idle_cnt = 0;
  bit in_burst = 1'b0;
  bit gap_valid = 1'b0;
  bit last_good = 1'b0;

  always #4 gmii_tx_clk = ~gmii_tx_clk;

  fifo9_gmii_tx_framer dut (
    .gmii_tx_clk   (gmii_tx_clk),
    .sys_rst       (sys_rst),
    .dout          (dout),
    .empty         (empty),
    .rd_en         (rd_en),
    .gmii_tx_en    (gmii_tx_en),
    .gmii_txd      (gmii_txd),
    .gmii_tx_er    (gmii_tx_er),
    .tx_frame_done (tx_frame_done),
    .tx_underrun   (tx_underrun)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Table-driven byte CRC for the model
  function automatic logic [31:0] crcByte(input logic [31:0] crc, input logic [7:0] b);
    return crc_table[crc[7:0] ^ b] ^ (crc >> 8);
  endfunction

  function automatic logic [7:0] dbyte(input int seed, input int i);
    return 8'((seed * 37 + i * 13 + (i >> 4)) & 255);
  endfunction

  task automatic expectByte(input logic er, input logic [7:0] b, input logic done, input logic und);
    exp_t e;
    e.er = er;
    e.txd = b;
    e.done = done;
    e.underrun = und;
    exp_q.push_back(e);
  endtask

  // kind 0: good frame, kind 1: underrun after cut bytes, kind 2: oversize
  task automatic expectFrame(input int len, input int seed, input int kind, input int cut);
    logic [31:0] crc;
    logic [31:0] fcs;
    logic [7:0]  b;
    int          n;
    for (int i = 0; i < 7; i++) expectByte(1'b0, 8'h55, 1'b0, 1'b0);
    expectByte(1'b0, 8'hD5, 1'b0, 1'b0);
    if (kind == 0) begin
      crc = 32'hFFFFFFFF;
      n = (len < 60) ? 60 : len;
      for (int i = 0; i < n; i++) begin
        b = (i < len) ? dbyte(seed, i) : 8'h00;
        crc = crcByte(crc, b);
        expectByte(1'b0, b, 1'b0, 1'b0);
      end
      fcs = ~crc;
      for (int k = 0; k < 4; k++) expectByte(1'b0, fcs[k*8 +: 8], (k == 3), 1'b0);
    end else if (kind == 1) begin
      for (int i = 0; i < cut; i++) expectByte(1'b0, dbyte(seed, i), 1'b0, 1'b0);
      expectByte(1'b1, 8'h00, 1'b0, 1'b1);
    end else begin
      for (int i = 0; i < 1514; i++) expectByte(1'b0, dbyte(seed, i), 1'b0, 1'b0);
      expectByte(1'b1, 8'h00, 1'b0, 1'b0);
    end
  endtask

  task automatic applyStimulus(input int len, input int seed, input int kind, input int cut);
    int n;
    n = (kind == 1) ? cut : len;
    for (int i = 0; i < n; i++) fifo_q.push_back({1'b1, dbyte(seed, i)});
    if (kind != 1) fifo_q.push_back(9'h000);
    expectFrame(len, seed, kind, cut);
  endtask

  task automatic pushTail(input int len, input int seed, input int from);
    for (int i = from; i < len; i++) fifo_q.push_back({1'b1, dbyte(seed, i)});
    fifo_q.push_back(9'h000);
  endtask

  task automatic pushSep(input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(9'h000);
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || gmii_tx_en) && n < 5000) begin
      @(negedge gmii_tx_clk);
      n++;
    end
    checkOutput(name, 32'(n < 5000), 32'd1);
    repeat (16) @(negedge gmii_tx_clk);
  endtask

  // FWFT FIFO: the pop request is sampled mid-cycle, the head moves just
  // after the rising edge that consumed it
  initial begin
    bit pop_now;
    dout = 9'h000;
    empty = 1'b1;
    forever begin
      @(negedge gmii_tx_clk);
      pop_now = rd_en;
      if (rd_en) checkOutput("rd_en_while_empty", 32'(empty), 32'd0);
      @(posedge gmii_tx_clk);
      #1;
      if (sys_rst) fifo_q.delete();
      else if (pop_now && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (fifo_q.size() > 0) begin
        dout = fifo_q[0];
        empty = 1'b0;
      end else begin
        dout = 9'h000;
        empty = 1'b1;
      end
    end
  end

  // Per-cycle compare against the expected wire stream, plus gap and
  // FCS-residue checks on every completed burst
  initial begin
    exp_t        e;
    logic [31:0] c;
    forever begin
      @(negedge gmii_tx_clk);
      if (sys_rst) begin
        in_burst = 1'b0;
        gap_valid = 1'b0;
        idle_cnt = 0;
        burst_len = 0;
        rx_q.delete();
      end else if (gmii_tx_en) begin
        if (!in_burst) begin
          if (gap_valid) checkOutput("ifg_min", 32'(idle_cnt >= 12), 32'd1);
          last_gap = idle_cnt;
          in_burst = 1'b1;
          burst_len = 0;
          rx_q.delete();
          last_good = 1'b0;
        end
        burst_len++;
        rx_q.push_back(gmii_txd);
        if (tx_frame_done) done_cnt++;
        if (tx_underrun) underrun_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_tx: got txd %0h, expected no transmission", gmii_txd);
        end else begin
          e = exp_q.pop_front();
          checkOutput($sformatf("stream[%0d]", burst_len),
                      32'({gmii_tx_er, gmii_txd, tx_frame_done, tx_underrun}), 32'(e));
          last_good = e.done;
        end
      end else begin
        checkOutput("idle_outputs", 32'({gmii_tx_er, gmii_txd, tx_frame_done, tx_underrun}), 32'd0);
        if (in_burst) begin
          in_burst = 1'b0;
          gap_valid = 1'b1;
          idle_cnt = 0;
          last_len = burst_len;
          if (last_good) begin
            c = 32'hFFFFFFFF;
            for (int i = 8; i < rx_q.size(); i++) c = crcByte(c, rx_q[i]);
            checkOutput("fcs_residue", c, CRC32_RESIDUE);
          end
        end
        idle_cnt++;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] c;
    logic [7:0]  msg [9];
    int          d0;
    int          u0;
    int          n;

    for (int k = 0; k < 256; k++) begin
      c = 32'(k);
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      crc_table[k] = c;
    end

    sys_rst = 1'b1;
    repeat (3) @(negedge gmii_tx_clk);
    checkOutput("reset_outputs", 32'({gmii_tx_en, gmii_txd, gmii_tx_er, tx_frame_done, tx_underrun, rd_en}), 32'd0);
    sys_rst = 1'b0;

    // Pin the CRC model: "123456789" check value and the FCS residue
    for (int i = 0; i < 9; i++) msg[i] = 8'h31 + 8'(i);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) c = crcByte(c, msg[i]);
    checkOutput("model_check_value", ~c, 32'hCBF43926);
    begin
      logic [31:0] f;
      f = ~c;
      for (int k = 0; k < 4; k++) c = crcByte(c, f[k*8 +: 8]);
    end
    checkOutput("model_residue", c, 32'hDEBB20E3);
    repeat (2) @(negedge gmii_tx_clk);

    $display("[TB] test 1: 60-byte frame");
    d0 = done_cnt;
    applyStimulus(60, 1, 0, 0);
    waitDrain("t1_timeout");
    checkOutput("t1_burst_len", 32'(last_len), 32'd72);
    checkOutput("t1_done_pulses", 32'(done_cnt - d0), 32'd1);

    $display("[TB] test 2: 14-byte frame padded");
    applyStimulus(14, 2, 0, 0);
    waitDrain("t2_timeout");
    checkOutput("t2_burst_len", 32'(last_len), 32'd72);

    $display("[TB] test 3: back-to-back frames");
    d0 = done_cnt;
    applyStimulus(64, 3, 0, 0);
    applyStimulus(61, 13, 0, 0);
    waitDrain("t3_timeout");
    checkOutput("t3_gap", 32'(last_gap), 32'd12);
    checkOutput("t3_burst_len", 32'(last_len), 32'd73);
    checkOutput("t3_done_pulses", 32'(done_cnt - d0), 32'd2);

    $display("[TB] test 4: underrun after 20 of 100 bytes");
    d0 = done_cnt;
    u0 = underrun_cnt;
    applyStimulus(100, 4, 1, 20);
    n = 0;
    while (underrun_cnt == u0 && n < 500) begin
      @(negedge gmii_tx_clk);
      n++;
    end
    checkOutput("t4_underrun_seen", 32'(n < 500), 32'd1);
    repeat (5) @(negedge gmii_tx_clk);
    pushTail(100, 4, 20);
    applyStimulus(64, 5, 0, 0);
    waitDrain("t4_timeout");
    checkOutput("t4_underrun_pulses", 32'(underrun_cnt - u0), 32'd1);
    checkOutput("t4_done_pulses", 32'(done_cnt - d0), 32'd1);
    checkOutput("t4_next_len", 32'(last_len), 32'd76);

    $display("[TB] test 5: 1600-byte oversize frame");
    d0 = done_cnt;
    u0 = underrun_cnt;
    applyStimulus(1600, 6, 2, 0);
    waitDrain("t5_timeout");
    checkOutput("t5_burst_len", 32'(last_len), 32'd1523);
    checkOutput("t5_done_pulses", 32'(done_cnt - d0), 32'd0);
    checkOutput("t5_underrun_pulses", 32'(underrun_cnt - u0), 32'd0);

    $display("[TB] test 6: leading separators, then reset mid-frame");
    d0 = done_cnt;
    pushSep(3);
    applyStimulus(20, 7, 0, 0);
    waitDrain("t6_timeout");
    checkOutput("t6_burst_len", 32'(last_len), 32'd72);
    checkOutput("t6_done_pulses", 32'(done_cnt - d0), 32'd1);

    applyStimulus(80, 8, 0, 0);
    n = 0;
    while (!(in_burst && burst_len >= 30) && n < 300) begin
      @(negedge gmii_tx_clk);
      n++;
    end
    checkOutput("t6_mid_frame_reached", 32'(n < 300), 32'd1);
    checkOutput("t6_tx_before_reset", 32'(gmii_tx_en), 32'd1);
    #1;
    sys_rst = 1'b1;
    #1;
    checkOutput("t6_async_reset", 32'({gmii_tx_en, gmii_txd, gmii_tx_er, tx_frame_done, tx_underrun}), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge gmii_tx_clk);
    sys_rst = 1'b0;
    repeat (2) @(negedge gmii_tx_clk);
    d0 = done_cnt;
    applyStimulus(61, 9, 0, 0);
    waitDrain("t6_post_reset_timeout");
    checkOutput("t6_post_reset_len", 32'(last_len), 32'd73);
    checkOutput("t6_post_reset_done", 32'(done_cnt - d0), 32'd1);

    checkOutput("expected_stream_consumed", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
